// File: rtl/mul_tree_pipe.sv
// mul_tree_pipe: parametrised, pipelined tree multiplier with valid/ready
// flow control. Every level holds when the output is stalled.
//
// Level map:
//   level 1           : captures a, b and the operation mode
//   levels 2..STAGES-1: carry-save (sum, carry) word of the reduced products
//   level STAGES      : carry-propagate add, result and overflow registers
// With STAGES == 2 the reduction and the final add both sit between level 1
// and the output register.
//
// Optional feature macro: MUL_TREE_SIGNED_EN
//   defined   : signed partial products are built and signed_mode selects
//               the mode for each operation
//   undefined : unsigned array only; signed_mode is ignored
//
// Parameters:
//   N      : operand width (N >= 4)
//   STAGES : register levels from operand capture to result (STAGES >= 2)
//
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous active-low reset
//   in_valid    : operand pair valid
//   in_ready    : operands accepted this cycle (combinational from out_ready)
//   a, b        : multiplicand, multiplier (N bits)
//   signed_mode : 1 = two's-complement operands, captured with a/b
//   out_valid   : result/overflow valid
//   out_ready   : sink accepts the result this cycle
//   result      : 2N-bit product
//   overflow    : product does not fit in N bits under the captured mode
module mul_tree_pipe #(
  parameter int N      = 32,
  parameter int STAGES = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result,
  output logic           overflow
);

  localparam int W   = 2 * N;
  localparam int MID = STAGES - 2;

  // A full output register that the sink refuses freezes the whole pipe.
  logic stall;
  logic advance;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign advance  = !stall;

  logic mode_in;
`ifdef MUL_TREE_SIGNED_EN
  assign mode_in = signed_mode;
`else
  // Port kept for compatibility; every operation is unsigned.
  assign mode_in = signed_mode & 1'b0;
`endif

  // ---------------- level 1: operand capture ----------------
  logic         v1;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  logic         m1;

  // NOTE: registers use non-blocking assignments so every level samples the
  // previous level's value from before the edge.
  always_ff @(posedge clk) begin
    if (!reset)       v1 <= 1'b0;
    else if (advance) v1 <= in_valid;
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide
  // whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (advance) begin
      a1 <= a;
      b1 <= b;
      m1 <= mode_in;
    end
  end

  // ---------------- partial products + carry-save reduction ----------------
  // One partial-product row per multiplier bit, folded into a (sum, carry)
  // pair with 3:2 compressors. In signed mode the multiplicand is sign
  // extended and the multiplier's MSB row carries weight -2^(N-1): that row
  // is inverted, and the matching +1 goes into carry bit 0, which the
  // compressor shift always leaves empty.
  logic [W-1:0] a_ext;
  logic [W-1:0] row;
  logic [W-1:0] sum_n;
  logic [W-1:0] carry_n;
  logic [W-1:0] pp_sum;
  logic [W-1:0] pp_carry;

  // NOTE: blocking assignments here are intentional: each compressor step
  // consumes the previous step's result within the same evaluation.
  always_comb begin
    row      = '0;
    sum_n    = '0;
    carry_n  = '0;
    pp_sum   = '0;
    pp_carry = '0;
`ifdef MUL_TREE_SIGNED_EN
    a_ext = {{N{m1 & a1[N-1]}}, a1};
`else
    a_ext = {{N{1'b0}}, a1};
`endif
    for (int i = 0; i < N; i++) begin
      row = b1[i] ? (a_ext << i) : '0;
`ifdef MUL_TREE_SIGNED_EN
      if (m1 && (i == N - 1)) row = ~row;
`endif
      sum_n    = pp_sum ^ pp_carry ^ row;
      carry_n  = ((pp_sum & pp_carry) | (pp_sum & row) | (pp_carry & row)) << 1;
      pp_sum   = sum_n;
      pp_carry = carry_n;
    end
`ifdef MUL_TREE_SIGNED_EN
    if (m1) pp_carry[0] = 1'b1;
`endif
  end

  // ---------------- levels 2..STAGES-1: carry-save word ----------------
  logic [W-1:0] fin_sum;
  logic [W-1:0] fin_carry;
  logic         fin_mode;
  logic         fin_valid;

  generate
    if (STAGES == 2) begin : g_direct
      assign fin_sum   = pp_sum;
      assign fin_carry = pp_carry;
      assign fin_mode  = m1;
      assign fin_valid = v1;
    end else begin : g_mid
      logic [MID-1:0][W-1:0] s_q;
      logic [MID-1:0][W-1:0] c_q;
      logic [MID-1:0]        m_q;
      logic [MID-1:0]        v_q;

      always_ff @(posedge clk) begin
        if (!reset) begin
          v_q <= '0;
        end else if (advance) begin
          v_q[0] <= v1;
          for (int j = 1; j < MID; j++) v_q[j] <= v_q[j-1];
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          s_q[0] <= pp_sum;
          c_q[0] <= pp_carry;
          m_q[0] <= m1;
          for (int j = 1; j < MID; j++) begin
            s_q[j] <= s_q[j-1];
            c_q[j] <= c_q[j-1];
            m_q[j] <= m_q[j-1];
          end
        end
      end

      assign fin_sum   = s_q[MID-1];
      assign fin_carry = c_q[MID-1];
      assign fin_mode  = m_q[MID-1];
      assign fin_valid = v_q[MID-1];
    end
  endgenerate

  // ---------------- level STAGES: final add and output ----------------
  logic [W-1:0] product;
  logic [N:0]   top_bits;
  logic         ovf_n;

  assign product  = fin_sum + fin_carry;
  assign top_bits = product[W-1:N-1];
  // Signed fit: the upper half plus bit N-1 must be pure sign extension.
  assign ovf_n    = fin_mode ? !((top_bits == '0) || (top_bits == '1))
                             : (product[W-1:N] != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (advance) begin
      out_valid <= fin_valid;
      result    <= product;
      overflow  <= ovf_n;
    end
  end

endmodule

// File: tb/tb_mul_tree_pipe.sv
// Scoreboard bench for mul_tree_pipe (N = 32, STAGES = 3).
// Accepted operand pairs push the reference product into a queue; a monitor
// pops and compares on each delivery, and also checks latency, hold during
// stalls and the in_ready rule. Directed vectors compare against constants.
module tb_mul_tree_pipe;

  localparam int N = 32;
  localparam int S = 3;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;

  mul_tree_pipe #(.N(N), .STAGES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks    = 0;
  int n_pass      = 0;
  int cyc         = 0;
  int stall_edges = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           edge_k;
    int           stalls;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: extend operands to 2N bits per the mode and multiply.
  function automatic logic [W:0] model(input logic [N-1:0] x,
                                       input logic [N-1:0] y,
                                       input logic sm);
    logic         mode;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic [W-1:0] p;
    logic [N:0]   top;
    logic         ov;
`ifdef MUL_TREE_SIGNED_EN
    mode = sm;
`else
    mode = sm & 1'b0;
`endif
    ex  = mode ? {{N{x[N-1]}}, x} : {{N{1'b0}}, x};
    ey  = mode ? {{N{y[N-1]}}, y} : {{N{1'b0}}, y};
    p   = ex * ey;
    top = p[W-1:N-1];
    ov  = mode ? !((top == '0) || (top == '1)) : (p[W-1:N] != '0);
    return {ov, p};
  endfunction

  function automatic logic [N-1:0] pick();
    case ($urandom % 6)
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(N-1){1'b0}}};
      3:       return N'($urandom % 16);
      default: return N'($urandom);
    endcase
  endfunction

  // Acceptance sampler: inputs are driven right after the falling edge, so
  // #1 later they show what the next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset === 1'b1) begin
        check("in_ready_rule", W'(in_ready), W'(!(out_valid && !out_ready)));
        if (in_valid && in_ready) begin
          exp_t e;
          logic [W:0] m;
          m        = model(a, b, signed_mode);
          e.res    = m[W-1:0];
          e.ovf    = m[W];
          e.edge_k = cyc + 1;
          e.stalls = stall_edges;
          sb.push_back(e);
        end
      end
    end
  end

  // Monitor: delivery at edge d of an item accepted at edge k must satisfy
  // d = k + S + (stall edges in between).
  logic         held_valid = 1'b0;
  logic [W-1:0] held_res;
  logic         held_ovf;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1) begin
        if (held_valid) begin
          check("hold_out_valid", W'(out_valid), W'(1));
          check("hold_result", result, held_res);
          check("hold_overflow", W'(overflow), W'(held_ovf));
        end
        held_valid = 1'b0;
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("spurious_out_valid", W'(out_valid), W'(0));
          end else if (out_ready) begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, e.res);
            check("overflow", W'(overflow), W'(e.ovf));
            check("latency", W'(cyc + 1 - e.edge_k), W'(S + stall_edges - e.stalls));
          end else begin
            stall_edges++;
            held_valid = 1'b1;
            held_res   = result;
            held_ovf   = overflow;
          end
        end
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  // One operation on an empty pipe, compared with spec constants.
  task automatic run_one(input string name, input logic [N-1:0] x,
                         input logic [N-1:0] y, input logic sm,
                         input logic [W-1:0] exp_res, input logic exp_ovf);
    int  k;
    bit  got;
    @(negedge clk);
    a = x; b = y; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      #3;
      if (out_valid) begin
        got = 1'b1;
        check({name, "_latency"}, W'(cyc - k), W'(S - 1));
        check({name, "_result"}, result, exp_res);
        check({name, "_overflow"}, W'(overflow), W'(exp_ovf));
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check({name, "_timeout"}, W'(out_valid), W'(1));
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
    check("drain_empty", W'(sb.size()), W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held for two edges with operands offered.
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; signed_mode = 1'b0;
    a = 32'd11; b = 32'd13;
    repeat (2) @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", result, W'(0));
    check("rst_overflow", W'(overflow), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    in_valid = 1'b0;
    reset    = 1'b1;

    // Directed vectors.
    run_one("u_3x5", 32'd3, 32'd5, 1'b0, 64'd15, 1'b0);
    run_one("u_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
`ifdef MUL_TREE_SIGNED_EN
    run_one("s_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1, 1'b0);
    run_one("s_min", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1);
    run_one("s_m2x3", 32'hFFFFFFFE, 32'd3, 1'b1, 64'hFFFFFFFFFFFFFFFA, 1'b0);
`else
    run_one("s_off", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE00000001, 1'b1);
`endif

    // Backpressure: 10 pairs streamed, sink stalls for 5 cycles mid-stream.
    begin
      int sent = 0;
      int i    = 0;
      bit pend = 1'b0;
      while (sent < 10 && i < 100) begin
        @(negedge clk);
        out_ready = !(i >= 4 && i < 9);
        if (!pend) begin
          a = N'($urandom); b = N'($urandom); signed_mode = 1'($urandom);
          pend = 1'b1;
        end
        in_valid = 1'b1;
        #1;
        if (in_ready) begin
          sent++;
          pend = 1'b0;
        end
        i++;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      drain();
    end

    // Bubbles: alternating in_valid with the sink always ready.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); a = pick(); b = pick(); signed_mode = 1'($urandom);
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Reset with two operations in flight: neither may ever come out.
    @(negedge clk);
    in_valid = 1'b1; a = 32'd100; b = 32'd200; signed_mode = 1'b0;
    @(negedge clk);
    a = 32'd300; b = 32'd400;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    #3;
    check("post_rst_out_valid", W'(out_valid), W'(0));
    repeat (5) @(negedge clk);
    run_one("after_rst", 32'd7, 32'd9, 1'b0, 64'd63, 1'b0);

    // Random soak with random source and sink handshakes.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid    = ($urandom % 4) != 0;
      out_ready   = ($urandom % 4) != 0;
      a           = pick();
      b           = pick();
      signed_mode = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_tree_pipe.md
# mul_tree_pipe

Parametrised, pipelined tree multiplier with valid/ready flow control. It is the successor to the fixed 32-bit registered tree multiplier. Width and pipeline depth are configurable, signed operation is optional, and the datapath accepts one operand pair per cycle with backpressure. It sits between an operand source (register file or ALU issue stage) and a result sink that may stall.

## Interface
Parameters:
- `N`, default 32: operand width; `N >= 4`.
- `STAGES`, default 3: total register levels from operand capture to result; `STAGES >= 2`.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand pair `a`, `b` (and `signed_mode`) is valid.
- `in_ready`  out  1  block accepts operands this cycle.
- `a`  in  N  multiplicand.
- `b`  in  N  multiplier.
- `signed_mode`  in  1  1 = two's-complement operands; 0 = unsigned. Captured with the operands.
- `out_valid`  out  1  `result` and `overflow` are valid.
- `out_ready`  in  1  sink accepts the result this cycle.
- `result`  out  2N  full-width product.
- `overflow`  out  1  product does not fit in N bits under the captured mode.

## Operation
- Accept: an operand pair is accepted when `in_valid && in_ready`.
- Deliver: a result is delivered when `out_valid && out_ready`.
- Stall rule:
  - `stall = out_valid && !out_ready`.
  - `in_ready = !stall`. This is a combinational path from `out_ready`.
  - When `stall` is high, every pipeline register, including its valid bit, holds.
  - When `stall` is low, all levels advance by one.
- Valid tracking: each level carries a valid bit. A level's valid bit loads 0 when it advances with no valid data behind it (a bubble).
- Level 1 captures `a`, `b` and `signed_mode`. Partial-product generation and carry-save reduction are split across levels 2..STAGES−1. The final carry-propagate add feeds level STAGES, which is the output register.
- Arithmetic:
  - Unsigned: `result = a * b`, zero-extended to 2N bits.
  - Signed: `result` is the 2N-bit two's-complement product.
- Overflow:
  - Unsigned: `overflow = |result[2N-1:N]`.
  - Signed: `overflow = 1` unless `result[2N-1:N-1]` is all zeros or all ones.
  - Computed from the same product word as `result` and registered with it.
- Reset (`reset == 0` at a clock edge):
  - All valid bits clear.
  - `out_valid = 0`, `result = 0`, `overflow = 0`.
  - In-flight operations are discarded, not completed.
- During reset, `in_ready` is 1 because `out_valid` is 0. Operands presented while reset is low are not accepted.

## Timing
- Latency: an operand accepted at edge k produces `out_valid = 1` after edge k+STAGES−1, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one result per cycle while `out_ready` is held high.
- Output stability: while `out_valid && !out_ready`, `result` and `overflow` stay stable.
- Input handshake: the source may change `a`/`b` freely when `in_valid` is 0. The block imposes no hold requirement on the source beyond the accepting edge.
- Simultaneous deliver and accept in the same cycle are both legal. The pipeline advances and no slot is lost.
- Reset and handshake in the same cycle: reset wins. No accept or deliver is counted.

## Configuration
- `MUL_TREE_SIGNED_EN`:
  - Defined: signed partial-product generation (Baugh-Wooley) is compiled in, and `signed_mode` selects the mode per operation.
  - Undefined: only the unsigned array is built. `signed_mode` stays in the port list but is ignored; every operation is unsigned and overflow uses the unsigned rule.

## Test plan
- Reset: hold `reset = 0` for 2 cycles with `in_valid = 1` -> `out_valid = 0`, `result = 0`, `overflow = 0`. Release reset -> the first accepted pair appears exactly STAGES−1 cycles later.
- Basic unsigned, N=32, STAGES=3: a=3, b=5, `signed_mode` = 0 -> `result` = 15, `overflow` = 0. Then a=b=0xFFFFFFFF -> `result` = 0xFFFFFFFE00000001, `overflow` = 1.
- Signed, macro defined: a=b=0xFFFFFFFF, `signed_mode` = 1 -> `result` = 1, `overflow` = 0. a=b=0x80000000 -> `result` = 0x4000000000000000, `overflow` = 1. a=0xFFFFFFFE, b=3 -> `result` = 0xFFFFFFFFFFFFFFFA, `overflow` = 0. With the macro undefined, the same first stimulus gives the unsigned result.
- Backpressure: stream 10 random pairs with `in_valid = 1` and drop `out_ready` for 5 cycles mid-stream -> `in_ready` = 0 exactly while stalled, outputs hold, all 10 results arrive in order and match the reference model.
- Bubbles: `in_valid` alternates 1/0 with `out_ready` = 1 -> `out_valid` alternates with the same pattern delayed by STAGES−1 cycles, and no spurious results appear.
- Reset mid-operation: assert reset with 2 operations in flight -> neither result is ever delivered. The next accepted pair completes with the normal latency.
